// File: rtl/hms_time_counter_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the timekeeping path (time counter, display driver).
//   - BCD digit widths for each field
//   - Field limits (seconds, minutes, 24-hour and 12-hour hour ranges)
//   - bcd_time_t: the full hh:mm:ss digit set, reused by the display driver
//   - hr_step_e: the kinds of step the hour digits can take on an increment
//   - tens_of/ones_of: split a decimal limit into its BCD digits at
//     elaboration time, so limits are written once as plain numbers
// -----------------------------------------------------------------------------
package clock_pkg;

  localparam int ONES_W     = 4;
  localparam int SEC_TENS_W = 3;
  localparam int MIN_TENS_W = 3;
  localparam int HR_TENS_W  = 2;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MIN = 1;
  localparam int HR12_MAX = 12;

  typedef struct packed {
    logic [HR_TENS_W-1:0]  hr_tens;
    logic [ONES_W-1:0]     hr_ones;
    logic [MIN_TENS_W-1:0] min_tens;
    logic [ONES_W-1:0]     min_ones;
    logic [SEC_TENS_W-1:0] sec_tens;
    logic [ONES_W-1:0]     sec_ones;
  } bcd_time_t;

  typedef enum logic [1:0] {
    HR_STEP_ONES,   // ones digit +1
    HR_STEP_TENS,   // ones 9 -> 0, tens +1
    HR_STEP_WRAP,   // top of range back to the bottom
    HR_STEP_PM_FLIP // 11 -> 12 in 12-hour mode, toggles pm
  } hr_step_e;

  function automatic int tens_of(input int value);
    return value / 10;
  endfunction

  function automatic int ones_of(input int value);
    return value % 10;
  endfunction

endpackage

// File: rtl/hms_time_counter_if.sv
// -----------------------------------------------------------------------------
// hms_time_counter_if
// Bundles the timekeeping stage's level/strobe inputs and its BCD time outputs.
//   master: drives tick_level/run/inc_min/inc_hour, observes the time
//   slave : the time counter itself
// Signals:
//   tick_level  divider square wave (asynchronous level)
//   run         1 = count seconds, 0 = hold
//   inc_min     one-cycle minute +1 strobe
//   inc_hour    one-cycle hour +1 strobe
//   sec_*/min_*/hr_*  BCD time digits
//   pm          12-hour mode afternoon flag (0 in 24-hour mode)
//   sec_strobe  one-cycle pulse per accepted second advance
// -----------------------------------------------------------------------------
interface hms_time_counter_if;
  import clock_pkg::*;

  logic                  tick_level;
  logic                  run;
  logic                  inc_min;
  logic                  inc_hour;
  logic [SEC_TENS_W-1:0] sec_tens;
  logic [ONES_W-1:0]     sec_ones;
  logic [MIN_TENS_W-1:0] min_tens;
  logic [ONES_W-1:0]     min_ones;
  logic [HR_TENS_W-1:0]  hr_tens;
  logic [ONES_W-1:0]     hr_ones;
  logic                  pm;
  logic                  sec_strobe;

  modport master (
    output tick_level, run, inc_min, inc_hour,
    input  sec_tens, sec_ones, min_tens, min_ones, hr_tens, hr_ones, pm, sec_strobe
  );

  modport slave (
    input  tick_level, run, inc_min, inc_hour,
    output sec_tens, sec_ones, min_tens, min_ones, hr_tens, hr_ones, pm, sec_strobe
  );

endinterface

// File: rtl/hms_time_counter_bcd_pair.sv
// -----------------------------------------------------------------------------
// bcd_pair_counter
// Two-digit BCD counter (tens/ones) counting 00 .. TENS_MAX ONES_MAX, then
// wrapping to 00. Digits are stepped by compare-to-limit, never via binary.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (count -> 00)
//   i_inc       advance by one this cycle
//   i_clr       force 00 this cycle (wins over i_inc)
//   o_tens      registered tens digit
//   o_ones      registered ones digit
//   o_carry     combinational: this cycle's increment wraps the pair to 00
// -----------------------------------------------------------------------------
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter int TENS_W   = 3,
  parameter int TENS_MAX = 5,
  parameter int ONES_MAX = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [TENS_W-1:0] o_tens,
  output logic [ONES_W-1:0] o_ones,
  output logic              o_carry
);

  logic [TENS_W-1:0] r_tens;
  logic [ONES_W-1:0] r_ones;
  logic              w_at_max;
  logic              w_ones_top;

  assign w_at_max   = (r_tens == TENS_W'(TENS_MAX)) && (r_ones == ONES_W'(ONES_MAX));
  assign w_ones_top = (r_ones == ONES_W'(9));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_tens <= '0;
        r_ones <= '0;
      end else if (w_ones_top) begin
        r_tens <= r_tens + TENS_W'(1);
        r_ones <= '0;
      end else begin
        r_ones <= r_ones + ONES_W'(1);
      end
    end
  end

  assign o_tens  = r_tens;
  assign o_ones  = r_ones;
  assign o_carry = i_inc & ~i_clr & w_at_max;

endmodule

// File: rtl/hms_time_counter.sv
// -----------------------------------------------------------------------------
// hms_time_counter
// Timekeeping stage fed by the clock divider. Synchronises the divider's
// square wave, turns each rising edge into a one-second event, and keeps
// hh:mm:ss in BCD. Set-time strobes step minutes/hours and clear seconds.
// Parameters:
//   MODE_24H     1 = hours 00..23; 0 = hours 12,1..11 with pm flag
//   SYNC_STAGES  synchroniser depth on tick_level (values below 2 use 2)
// Ports:
//   clk_in  system clock, all logic on posedge
//   rst_n   asynchronous active-low reset
//   tc      hms_time_counter_if.slave: tick_level/run/strobes in, BCD time out
// -----------------------------------------------------------------------------
module hms_time_counter
  import clock_pkg::*;
#(
  parameter int MODE_24H    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_in,
  input  logic               rst_n,
  hms_time_counter_if.slave  tc
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [HR_TENS_W-1:0] HR_RST_TENS =
    (MODE_24H != 0) ? '0 : HR_TENS_W'(tens_of(HR12_MAX));
  localparam logic [ONES_W-1:0]    HR_RST_ONES =
    (MODE_24H != 0) ? '0 : ONES_W'(ones_of(HR12_MAX));

  // ---------------------------------------------------------------------------
  // Tick synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_N-1:0] r_sync;
  logic [SYNC_N-1:0] r_valid;     // marks which sync stages hold real samples
  logic              r_tick_hist; // previous value of the last sync stage
  logic              r_armed;     // a genuine low level has been seen
  logic              w_sync_last;
  logic              w_rise;

  assign w_sync_last = r_sync[SYNC_N-1];

  // The reset zeros flowing out of the synchroniser would otherwise look like
  // a low level, so a tick already high at release would count as an edge.
  // r_armed only sets once a real sampled low reaches the last stage.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_valid     <= '0;
      r_tick_hist <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_N-2:0], tc.tick_level};
      r_valid     <= {r_valid[SYNC_N-2:0], 1'b1};
      r_tick_hist <= w_sync_last;
      r_armed     <= r_armed | (r_valid[SYNC_N-1] & ~w_sync_last);
    end
  end

  assign w_rise = w_sync_last & ~r_tick_hist & r_armed;

  // ---------------------------------------------------------------------------
  // Event decode: set strobes take priority and swallow a coincident rise
  // ---------------------------------------------------------------------------
  logic w_set;
  logic w_adv;

  assign w_set = tc.inc_min | tc.inc_hour;
  assign w_adv = w_rise & tc.run & ~w_set;

  // ---------------------------------------------------------------------------
  // Seconds and minutes
  // ---------------------------------------------------------------------------
  logic [SEC_TENS_W-1:0] w_sec_tens;
  logic [ONES_W-1:0]     w_sec_ones;
  logic [MIN_TENS_W-1:0] w_min_tens;
  logic [ONES_W-1:0]     w_min_ones;
  logic                  w_sec_carry;
  logic                  w_min_carry;
  logic                  w_min_inc;

  bcd_pair_counter #(
    .TENS_W   (SEC_TENS_W),
    .TENS_MAX (tens_of(SEC_MAX)),
    .ONES_MAX (ones_of(SEC_MAX))
  ) u_sec (
    .clk     (clk_in),
    .rst_n   (rst_n),
    .i_inc   (w_adv),
    .i_clr   (w_set),
    .o_tens  (w_sec_tens),
    .o_ones  (w_sec_ones),
    .o_carry (w_sec_carry)
  );

  assign w_min_inc = tc.inc_min | w_sec_carry;

  bcd_pair_counter #(
    .TENS_W   (MIN_TENS_W),
    .TENS_MAX (tens_of(MIN_MAX)),
    .ONES_MAX (ones_of(MIN_MAX))
  ) u_min (
    .clk     (clk_in),
    .rst_n   (rst_n),
    .i_inc   (w_min_inc),
    .i_clr   (1'b0),
    .o_tens  (w_min_tens),
    .o_ones  (w_min_ones),
    .o_carry (w_min_carry)
  );

  // ---------------------------------------------------------------------------
  // Hours: dedicated logic for the 12/24-hour wrap and pm flag
  // ---------------------------------------------------------------------------
  logic [HR_TENS_W-1:0] r_hr_tens;
  logic [ONES_W-1:0]    r_hr_ones;
  logic                 r_pm;
  logic                 w_hr_inc;
  hr_step_e             w_hr_step;
  logic [HR_TENS_W-1:0] w_hr_tens_nxt;
  logic [ONES_W-1:0]    w_hr_ones_nxt;
  logic                 w_pm_nxt;

  // A minute wrap from a set strobe never reaches the hours; only a counted
  // second that rolls both seconds and minutes does.
  assign w_hr_inc = tc.inc_hour | (w_adv & w_min_carry);

  // NOTE: every combinational output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    w_hr_step = HR_STEP_ONES;
    if (MODE_24H != 0) begin
      if (r_hr_tens == HR_TENS_W'(tens_of(HR24_MAX)) &&
          r_hr_ones == ONES_W'(ones_of(HR24_MAX))) begin
        w_hr_step = HR_STEP_WRAP;
      end else if (r_hr_ones == ONES_W'(9)) begin
        w_hr_step = HR_STEP_TENS;
      end
    end else begin
      if (r_hr_tens == HR_TENS_W'(tens_of(HR12_MAX)) &&
          r_hr_ones == ONES_W'(ones_of(HR12_MAX))) begin
        w_hr_step = HR_STEP_WRAP;
      end else if (r_hr_tens == HR_TENS_W'(tens_of(HR12_MAX - 1)) &&
                   r_hr_ones == ONES_W'(ones_of(HR12_MAX - 1))) begin
        w_hr_step = HR_STEP_PM_FLIP;
      end else if (r_hr_ones == ONES_W'(9)) begin
        w_hr_step = HR_STEP_TENS;
      end
    end
  end

  always_comb begin
    w_hr_tens_nxt = r_hr_tens;
    w_hr_ones_nxt = r_hr_ones;
    w_pm_nxt      = r_pm;
    unique case (w_hr_step)
      HR_STEP_ONES: begin
        w_hr_ones_nxt = r_hr_ones + ONES_W'(1);
      end
      HR_STEP_TENS: begin
        w_hr_tens_nxt = r_hr_tens + HR_TENS_W'(1);
        w_hr_ones_nxt = '0;
      end
      HR_STEP_WRAP: begin
        if (MODE_24H != 0) begin
          w_hr_tens_nxt = '0;
          w_hr_ones_nxt = '0;
        end else begin
          w_hr_tens_nxt = HR_TENS_W'(tens_of(HR12_MIN));
          w_hr_ones_nxt = ONES_W'(ones_of(HR12_MIN));
        end
      end
      HR_STEP_PM_FLIP: begin
        w_hr_tens_nxt = HR_TENS_W'(tens_of(HR12_MAX));
        w_hr_ones_nxt = ONES_W'(ones_of(HR12_MAX));
        w_pm_nxt      = ~r_pm;
      end
      default: ;
    endcase
  end

  // NOTE: only a handful of control/time flops exist here, so all of them take
  // the asynchronous reset; nothing is left to power up undefined.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_hr_tens <= HR_RST_TENS;
      r_hr_ones <= HR_RST_ONES;
      r_pm      <= 1'b0;
    end else if (w_hr_inc) begin
      r_hr_tens <= w_hr_tens_nxt;
      r_hr_ones <= w_hr_ones_nxt;
      r_pm      <= w_pm_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Second strobe, registered alongside the time digits
  // ---------------------------------------------------------------------------
  logic r_sec_strobe;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_strobe <= 1'b0;
    end else begin
      r_sec_strobe <= w_adv;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // ---------------------------------------------------------------------------
  bcd_time_t w_time;

  assign w_time = '{hr_tens:  r_hr_tens,  hr_ones:  r_hr_ones,
                    min_tens: w_min_tens, min_ones: w_min_ones,
                    sec_tens: w_sec_tens, sec_ones: w_sec_ones};

  assign tc.sec_tens   = w_time.sec_tens;
  assign tc.sec_ones   = w_time.sec_ones;
  assign tc.min_tens   = w_time.min_tens;
  assign tc.min_ones   = w_time.min_ones;
  assign tc.hr_tens    = w_time.hr_tens;
  assign tc.hr_ones    = w_time.hr_ones;
  assign tc.pm         = r_pm;
  assign tc.sec_strobe = r_sec_strobe;

endmodule
